// File: rtl/alu_181_seq.sv
// Multi-cycle 74181-style ALU. Operands are processed as 4-bit slices,
// SLICES_PER_CYCLE slices per clock, with the active-low ripple carry held
// in a register between steps. Valid/ready on both sides.

// One SN74181 slice, active-high data, active-low carry.
module alu181_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] sel_i,
    input  logic       mode_i,
    input  logic       cn_i,
    output logic [3:0] f_o,
    output logic       cn4_o
);
    logic [3:0] t1, t2;
    logic [4:0] sum;

    // t1/t2 are the complements of the chip's internal X/Y terms; the
    // arithmetic result is t1 + t2 + carry, the logic result is ~(t1 ^ t2).
    always_comb begin
        t1    = a_i | (b_i & {4{sel_i[0]}}) | (~b_i & {4{sel_i[1]}});
        t2    = (a_i & ~b_i & {4{sel_i[2]}}) | (a_i & b_i & {4{sel_i[3]}});
        sum   = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~cn_i};
        f_o   = mode_i ? ~(t1 ^ t2) : sum[3:0];
        cn4_o = ~sum[4];
    end
endmodule

module alu_181_seq #(
    parameter int WIDTH            = 32,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic [3:0]       sel,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             a_eq_b,
    output logic             zero
);
    localparam int SPC   = SLICES_PER_CYCLE;
    localparam int NSTEP = WIDTH / (4 * SPC);
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int IW    = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [3:0]       sel_q;
    logic             mode_q, cy_q, co_q, aeqb_q, zero_q, ovld_q;
    logic             last_step, accept;

    logic [IW-1:0]             base;
    logic [SPC:0]              cy_chain;
    logic [SPC-1:0][3:0]       a_sl, b_sl, f_sl;

    assign base        = IW'(cnt_q) * IW'(4 * SPC);
    assign cy_chain[0] = cy_q;
    assign last_step   = (cnt_q == CW'(NSTEP - 1));
    assign in_ready    = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept      = in_valid & in_ready;

    // Slices of the current step, carry rippling bottom to top.
    for (genvar k = 0; k < SPC; k++) begin : g_slice
        assign a_sl[k] = a_q[base + IW'(4 * k) +: 4];
        assign b_sl[k] = b_q[base + IW'(4 * k) +: 4];
        alu181_slice u_slice (
            .a_i   (a_sl[k]),
            .b_i   (b_sl[k]),
            .sel_i (sel_q),
            .mode_i(mode_q),
            .cn_i  (cy_chain[k]),
            .f_o   (f_sl[k]),
            .cn4_o (cy_chain[k+1])
        );
    end

    // Merge this step's slice outputs into the result word.
    always_comb begin
        res_d = res_q;
        for (int k = 0; k < SPC; k++) begin
            res_d[base + IW'(4 * k) +: 4] = f_sl[k];
        end
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            cy_q    <= 1'b1;
            res_q   <= '0;
            co_q    <= 1'b1;
            aeqb_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovld_q  <= 1'b0;
        end else if (accept) begin
            state_q <= RUN;
            cnt_q   <= '0;
            a_q     <= a;
            b_q     <= b;
            sel_q   <= sel;
            mode_q  <= mode;
            cy_q    <= carry_in;
            ovld_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    res_q <= res_d;
                    cy_q  <= cy_chain[SPC];
                    if (last_step) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        ovld_q  <= 1'b1;
                        co_q    <= cy_chain[SPC];
                        aeqb_q  <= &res_d;
                        zero_q  <= ~|res_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        ovld_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = ovld_q;
    assign result    = res_q;
    assign carry_out = co_q;
    assign a_eq_b    = aeqb_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_181_seq.sv
// Directed bench for alu_181_seq: table of hand-computed vectors on a
// 32-bit one-slice-per-cycle instance, plus backpressure and reset-abort
// sequences, plus a single-cycle (8 slices/cycle) instance.
module tb_alu_181_seq;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        mode;
        logic [3:0]  sel;
        logic        ci;
        logic [31:0] res;
        logic        co;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        mode = 1'b0, carry_in = 1'b1;
    logic [3:0]  sel = '0;
    logic        iv1 = 1'b0, iv2 = 1'b0, or1 = 1'b0, or2 = 1'b0;
    logic        rdy1, rdy2, ov1, ov2, co1, co2, eq1, eq2, z1, z2;
    logic [31:0] res1, res2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
        .a(a), .b(b), .mode(mode), .sel(sel), .carry_in(carry_in),
        .out_valid(ov1), .out_ready(or1), .result(res1),
        .carry_out(co1), .a_eq_b(eq1), .zero(z1)
    );

    alu_181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(rdy2),
        .a(a), .b(b), .mode(mode), .sel(sel), .carry_in(carry_in),
        .out_valid(ov2), .out_ready(or2), .result(res2),
        .carry_out(co2), .a_eq_b(eq2), .zero(z2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; mode = v.mode; sel = v.sel; carry_in = v.ci;
    endtask

    // Issue one op, wait (bounded) for out_valid, check it, then drain it.
    task automatic run_op(input vec_t v, input int which, input int exp_lat, input string tag);
        int lat = 0;
        int bad_rdy = 0;
        bit done = 0;
        @(negedge clk);
        drive(v);
        if (which == 1) iv1 = 1'b1; else iv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0; iv2 = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((which == 1) ? ov1 : ov2) done = 1;
            else if ((which == 1) ? rdy1 : rdy2) bad_rdy++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " in_ready_run"}, bad_rdy, 0);
        chk({tag, " result"}, (which == 1) ? res1 : res2, v.res);
        chk({tag, " carry_out"}, 32'((which == 1) ? co1 : co2), 32'(v.co));
        chk({tag, " zero"}, 32'((which == 1) ? z1 : z2), 32'(v.res == 32'h0));
        chk({tag, " a_eq_b"}, 32'((which == 1) ? eq1 : eq2), 32'(&v.res));
        if (which == 1) or1 = 1'b1; else or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or1 = 1'b0; or2 = 1'b0;
        chk({tag, " out_valid_drop"}, 32'((which == 1) ? ov1 : ov2), 32'h0);
    endtask

    vec_t vt[12];

    initial begin
        int lat, bad;
        vec_t v;
        //        a             b             M     S        ci    result        co
        vt[0]  = '{32'h00000001, 32'h00000003, 1'b0, 4'b1001, 1'b1, 32'h00000004, 1'b1};
        vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b1001, 1'b1, 32'h00000000, 1'b0};
        vt[2]  = '{32'h12345678, 32'h12345678, 1'b0, 4'b0110, 1'b1, 32'hFFFFFFFF, 1'b1};
        vt[3]  = '{32'h12345678, 32'h12345678, 1'b0, 4'b0110, 1'b0, 32'h00000000, 1'b0};
        vt[4]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b1, 4'b0100, 1'b1, 32'hFFFFFFFE, 1'b0};
        vt[5]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b1, 4'b0110, 1'b1, 32'hFFFFFFFE, 1'b0};
        vt[6]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b1, 4'b1011, 1'b1, 32'h00000001, 1'b0};
        vt[7]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b1, 4'b1110, 1'b1, 32'hFFFFFFFF, 1'b0};
        vt[8]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b0, 4'b0011, 1'b1, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{32'hFFFF0001, 32'h0000FFFF, 1'b0, 4'b0011, 1'b0, 32'h00000000, 1'b0};
        vt[10] = '{32'h00000005, 32'h00000003, 1'b0, 4'b0110, 1'b0, 32'h00000002, 1'b0};
        vt[11] = '{32'h80000001, 32'h00000000, 1'b0, 4'b1100, 1'b1, 32'h00000002, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst out_valid", 32'(ov1), 32'h0);
        chk("rst in_ready", 32'(rdy1), 32'h1);
        chk("rst result", res1, 32'h0);
        chk("rst carry_out", 32'(co1), 32'h1);
        chk("rst zero", 32'(z1), 32'h0);
        chk("rst a_eq_b", 32'(eq1), 32'h0);
        chk("rst in_ready2", 32'(rdy2), 32'h1);

        for (int i = 0; i < 12; i++) run_op(vt[i], 1, 8, $sformatf("vec%0d", i));

        // Single-cycle instance
        run_op(vt[1], 2, 1, "spc8 wrap");
        run_op(vt[0], 2, 1, "spc8 add");

        // Backpressure in DONE with a pending new op
        @(negedge clk);
        drive(vt[0]);
        iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
        chk("bp first valid", 32'(ov1), 32'h1);
        a = 32'd10; b = 32'd20; mode = 1'b0; sel = 4'b1001; carry_in = 1'b1;
        iv1 = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (res1 !== 32'h4 || ov1 !== 1'b1 || rdy1 !== 1'b0 || co1 !== 1'b1) bad++;
        end
        chk("bp hold", bad, 0);
        or1 = 1'b1;
        #1;
        chk("bp in_ready", 32'(rdy1), 32'h1);
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0; or1 = 1'b0;
        chk("bp valid drop", 32'(ov1), 32'h0);
        lat = 0;
        while (!ov1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
        chk("bp latency", lat, 8);
        chk("bp result", res1, 32'd30);
        or1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or1 = 1'b0;

        // Reset in the middle of RUN
        v = '{32'h00000007, 32'h00000009, 1'b0, 4'b1001, 1'b1, 32'h00000010, 1'b1};
        drive(v);
        iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("abort out_valid", 32'(ov1), 32'h0);
        chk("abort in_ready", 32'(rdy1), 32'h1);
        chk("abort result", res1, 32'h0);
        chk("abort carry_out", 32'(co1), 32'h1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov1 !== 1'b0) bad++;
        end
        chk("abort no valid", bad, 0);
        run_op(v, 1, 8, "after abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
